chunked_addsub: RTL and testbench
=================================

// Module: chunked_addsub
// PURPOSE
//  Multi-cycle wide adder/subtractor for the large-multiplication datapath.
//  Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the
//  carry between chunks through a register, so WIDTH can grow without a
//  WIDTH-long combinational carry chain. Sits after the Wallace reduction tree
//  as the final carry-propagate stage, behind valid/ready handshakes.
// PARAMETERS
//  WIDTH   2048  operand/result width in bits
//  CHUNK   64    bits added per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
//  NCHUNK  WIDTH/CHUNK (localparam) chunks per operation; counter is clog2(NCHUNK)+1 bits
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      block can accept an operation
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: s=a+b+cin; 1: s=a-b-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  s          out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      add: carry out; sub: 1 = no borrow (a >= b+cin)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, s=0, cout=0,
//   chunk counter=0, carry reg=0. Reset mid-operation aborts it; no out_valid.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid&&in_ready: latch a, b^{WIDTH{sub}},
//    carry=cin^sub, cnt=0 -> RUN. Inputs otherwise ignored.
//   RUN: in_ready=0. Each edge: {c,s[cnt*CHUNK +: CHUNK]} = a_k + b_k + carry;
//    carry<=c; cnt<=cnt+1. When the chunk NCHUNK-1 is written: cout<=c -> DONE.
//   DONE: out_valid=1; s, cout stable until out_ready=1, then IDLE
//    (out_valid drops the following cycle). in_ready=0 in DONE, so a
//    handshake cannot be accepted on the DONE->IDLE edge.
//  Latency: out_valid rises exactly NCHUNK edges after the accept edge.
//   NCHUNK=1 legal: one RUN cycle. Throughput: one op per NCHUNK+2 cycles
//   with out_ready held high.
//  s/cout hold last result in IDLE; s chunks not yet computed in RUN hold old
//   values (do not sample s unless out_valid=1).
//  Arithmetic: all sums mod 2^WIDTH; no signed overflow flag.
//   sub: s = a + ~b + ~cin, cout = carry out of that sum.
//  Simultaneous events: in_valid while busy -> held off by in_ready=0;
//   out_ready while not DONE -> ignored.
// TESTING (bench configs WIDTH=2048/CHUNK=64 and WIDTH=16/CHUNK=4; ref model a+b+cin)
//  1 Reset: rst_n low mid-RUN -> out_valid=0, in_ready=1, s=0, cout=0 immediately,
//    no result ever presented for the aborted op.
//  2 W16/C4 add a=16'hFFFF,b=16'h0001,cin=0 -> s=16'h0000,cout=1, out_valid
//    exactly 4 edges after accept.
//  3 W16/C4 sub a=16'h0005,b=16'h0007,cin=0 -> s=16'hFFFE,cout=0;
//    a=16'h0007,b=16'h0005,cin=1 -> s=16'h0001,cout=1.
//  4 W2048 full carry ripple: a=all-ones,b=0,cin=1 -> s=0,cout=1 after 32 edges.
//  5 Backpressure: hold out_ready=0 10 cycles with in_valid=1 -> s/cout stable,
//    in_ready=0, second op accepted only after DONE->IDLE.
//  6 Random 1000 ops, random sub/cin/out_ready, both configs -> matches model,
//    no lost/duplicated results; also NCHUNK=1 (W16/C16) case passes.

Source files
------------

// File: rtl/chunked_addsub_if.sv
// rtl/chunked_addsub_if.sv - operand/result handshake bundle for chunked_addsub
// master drives operands and result acceptance; slave is the adder.
interface chunked_addsub_if #(
  parameter int WIDTH = 2048
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout
  );
endinterface

// File: rtl/chunked_addsub.sv
// rtl/chunked_addsub.sv - multi-cycle WIDTH-bit add/sub, CHUNK bits per clock
// Carry ripples between chunks through a register; subtraction is a + ~b + ~cin.
module chunked_addsub #(
  parameter int WIDTH = 2048,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  chunked_addsub_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             accept;
  logic             in_ready_c;
  logic             out_valid_c;

  assign base       = 32'(cnt_q) * 32'(CHUNK);
  assign a_k        = CHUNK'(a_q >> base);
  assign b_k        = CHUNK'(b_q >> base);
  assign chunk_sum  = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));
  assign accept     = in_ready_c && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the chunk under the counter is rewritten; the rest of s keeps its old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b ^ {WIDTH{bus.sub}};
      carry_q <= bus.cin ^ bus.sub;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      s_q     <= (s_q & ~(CHUNK_MASK << base)) |
                 (WIDTH'(chunk_sum[CHUNK-1:0]) << base);
      carry_q <= chunk_sum[CHUNK];
      cnt_q   <= cnt_q + CW'(1);
      if (last_chunk) cout_q <= chunk_sum[CHUNK];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// tb/tb_chunked_addsub.sv - directed and random checks of chunked_addsub
// Three instances: W2048/C64 (id 0), W16/C4 (id 1), W16/C16 (id 2).
module tb_chunked_addsub;
  typedef logic [2048:0] wide_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  chunked_addsub_if #(.WIDTH(2048)) bus_big ();
  chunked_addsub_if #(.WIDTH(16))   bus_w16 ();
  chunked_addsub_if #(.WIDTH(16))   bus_n1 ();

  chunked_addsub #(.WIDTH(2048), .CHUNK(64)) dut_big (.clk(clk), .rst_n(rst_n), .bus(bus_big));
  chunked_addsub #(.WIDTH(16),   .CHUNK(4))  dut_w16 (.clk(clk), .rst_n(rst_n), .bus(bus_w16));
  chunked_addsub #(.WIDTH(16),   .CHUNK(16)) dut_n1  (.clk(clk), .rst_n(rst_n), .bus(bus_n1));

  task automatic check(input string tag, input wide_t got, input wide_t exp);
    int diff_bit;
    checks++;
    if (got !== exp) begin
      errors++;
      diff_bit = -1;
      for (int i = 2048; i >= 0; i--) if (got[i] !== exp[i] && diff_bit < 0) diff_bit = i;
      $display("FAIL %s: got(low128)=%0h expected(low128)=%0h first differing bit=%0d",
               tag, got[127:0], exp[127:0], diff_bit);
    end
  endtask

  function automatic int width_of(input int w);
    return (w == 0) ? 2048 : 16;
  endfunction

  function automatic int nchunk_of(input int w);
    return (w == 0) ? 32 : ((w == 1) ? 4 : 1);
  endfunction

  task automatic set_in(input int w, input logic v, input wide_t a, input wide_t b,
                        input logic cin, input logic sub);
    case (w)
      0: begin bus_big.in_valid = v; bus_big.a = a[2047:0]; bus_big.b = b[2047:0];
               bus_big.cin = cin; bus_big.sub = sub; end
      1: begin bus_w16.in_valid = v; bus_w16.a = a[15:0]; bus_w16.b = b[15:0];
               bus_w16.cin = cin; bus_w16.sub = sub; end
      default: begin bus_n1.in_valid = v; bus_n1.a = a[15:0]; bus_n1.b = b[15:0];
               bus_n1.cin = cin; bus_n1.sub = sub; end
    endcase
  endtask

  task automatic set_out_ready(input int w, input logic r);
    case (w)
      0: bus_big.out_ready = r;
      1: bus_w16.out_ready = r;
      default: bus_n1.out_ready = r;
    endcase
  endtask

  function automatic logic get_in_ready(input int w);
    return (w == 0) ? bus_big.in_ready : ((w == 1) ? bus_w16.in_ready : bus_n1.in_ready);
  endfunction

  function automatic logic get_out_valid(input int w);
    return (w == 0) ? bus_big.out_valid : ((w == 1) ? bus_w16.out_valid : bus_n1.out_valid);
  endfunction

  function automatic wide_t get_s(input int w);
    return (w == 0) ? wide_t'(bus_big.s) : ((w == 1) ? wide_t'(bus_w16.s) : wide_t'(bus_n1.s));
  endfunction

  function automatic logic get_cout(input int w);
    return (w == 0) ? bus_big.cout : ((w == 1) ? bus_w16.cout : bus_n1.cout);
  endfunction

  // Reference: add is a+b+cin; sub is a-b-cin with cout = no borrow.
  task automatic model(input int w, input wide_t a, input wide_t b, input logic cin,
                       input logic sub, output wide_t s, output logic c);
    wide_t mask, aa, bb, t;
    mask = (wide_t'(1) << width_of(w)) - wide_t'(1);
    aa = a & mask;
    bb = b & mask;
    if (!sub) begin
      t = aa + bb + wide_t'(cin);
      s = t & mask;
      c = t[width_of(w)];
    end else begin
      s = (aa - bb - wide_t'(cin)) & mask;
      c = (aa >= bb + wide_t'(cin));
    end
  endtask

  function automatic wide_t rand_wide();
    wide_t r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = {1'b0, {2048{1'b1}}};
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_op(input int w, input wide_t a, input wide_t b, input logic cin,
                        input logic sub, input int hold, input logic early,
                        input wide_t exp_s, input logic exp_c, input string tag);
    int n;
    int edges;
    n = 0;
    while (!get_in_ready(w) && n < 200) begin @(negedge clk); n++; end
    check({tag, ".in_ready"}, wide_t'(get_in_ready(w)), wide_t'(1));
    set_in(w, 1'b1, a, b, cin, sub);
    if (early) set_out_ready(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, ~a, ~b, ~cin, ~sub);
    edges = 0;
    while (!get_out_valid(w) && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, ".latency"}, wide_t'(edges), wide_t'(nchunk_of(w)));
    check({tag, ".s"}, get_s(w), exp_s);
    check({tag, ".cout"}, wide_t'(get_cout(w)), wide_t'(exp_c));
    if (!early) begin
      repeat (hold) @(negedge clk);
      check({tag, ".held_valid"}, wide_t'(get_out_valid(w)), wide_t'(1));
      check({tag, ".held_s"}, get_s(w), exp_s);
      set_out_ready(w, 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    set_out_ready(w, 1'b0);
    check({tag, ".valid_drop"}, wide_t'(get_out_valid(w)), wide_t'(0));
    check({tag, ".idle_s"}, get_s(w), exp_s);
  endtask

  wide_t ones;
  wide_t ra, rb, es;
  logic  rc, rsub, ec;
  int    edges, seen_valid;

  initial begin
    ones = {1'b0, {2048{1'b1}}};
    rst_n = 1'b0;
    for (int w = 0; w < 3; w++) begin
      set_in(w, 1'b0, '0, '0, 1'b0, 1'b0);
      set_out_ready(w, 1'b0);
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      check("reset.in_ready", wide_t'(get_in_ready(w)), wide_t'(1));
      check("reset.out_valid", wide_t'(get_out_valid(w)), wide_t'(0));
      check("reset.s", get_s(w), '0);
      check("reset.cout", wide_t'(get_cout(w)), wide_t'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1, 'h FFFF, 'h 0001, 1'b0, 1'b0, 2, 1'b0, 'h 0000, 1'b1, "w16_add_wrap");
    run_op(1, 'h 0005, 'h 0007, 1'b0, 1'b1, 1, 1'b0, 'h FFFE, 1'b0, "w16_sub_borrow");
    run_op(1, 'h 0007, 'h 0005, 1'b1, 1'b1, 0, 1'b1, 'h 0001, 1'b1, "w16_sub_cin");
    run_op(0, ones, '0, 1'b1, 1'b0, 1, 1'b0, '0, 1'b1, "big_full_ripple");
    run_op(0, '0, 'h 1, 1'b0, 1'b1, 0, 1'b0, ones, 1'b0, "big_sub_under");
    run_op(2, 'h FFFF, 'h 0001, 1'b0, 1'b0, 0, 1'b0, 'h 0000, 1'b1, "n1_add_wrap");
    run_op(2, 'h 0000, 'h 0000, 1'b1, 1'b1, 1, 1'b1, 'h FFFF, 1'b0, "n1_sub_cin");

    // Abort a big op mid-RUN with reset; its result must never appear.
    set_in(0, 1'b1, 'h 1, 'h 1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", wide_t'(get_out_valid(0)), wide_t'(0));
    check("abort.in_ready", wide_t'(get_in_ready(0)), wide_t'(1));
    check("abort.s", get_s(0), '0);
    check("abort.cout", wide_t'(get_cout(0)), wide_t'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (get_out_valid(0)) seen_valid++;
    end
    check("abort.no_result", wide_t'(seen_valid), wide_t'(0));

    // Backpressure: second op waits on in_valid until DONE->IDLE.
    set_in(1, 1'b1, 'h 1234, 'h 1111, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(1, 1'b1, 'h 8000, 'h 8000, 1'b1, 1'b0);
    edges = 0;
    while (!get_out_valid(1) && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("bp.latency", wide_t'(edges), wide_t'(4));
    for (int i = 0; i < 10; i++) begin
      check("bp.s", get_s(1), 'h 2345);
      check("bp.cout", wide_t'(get_cout(1)), wide_t'(0));
      check("bp.in_ready", wide_t'(get_in_ready(1)), wide_t'(0));
      @(negedge clk);
    end
    set_out_ready(1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_out_ready(1, 1'b0);
    check("bp.idle_in_ready", wide_t'(get_in_ready(1)), wide_t'(1));
    check("bp.idle_valid", wide_t'(get_out_valid(1)), wide_t'(0));
    @(posedge clk);
    @(negedge clk);
    set_in(1, 1'b0, '0, '0, 1'b0, 1'b0);
    check("bp.second_accepted", wide_t'(get_in_ready(1)), wide_t'(0));
    edges = 0;
    while (!get_out_valid(1) && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("bp.second_latency", wide_t'(edges), wide_t'(4));
    check("bp.second_s", get_s(1), 'h 0001);
    check("bp.second_cout", wide_t'(get_cout(1)), wide_t'(1));
    set_out_ready(1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_out_ready(1, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      automatic int w = (k < 300) ? 0 : ((k < 700) ? 1 : 2);
      ra   = rand_wide();
      rb   = rand_wide();
      rc   = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      model(w, ra, rb, rc, rsub, es, ec);
      run_op(w, ra, rb, rc, rsub, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
             es, ec, $sformatf("rand%0d_w%0d", k, w));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
